data_sram_like_bridge: RTL and testbench
========================================

Name: data_sram_like_bridge

Overview:
Sits directly downstream of the CPU core's data-memory port, after the MMU's physical-address translation. It converts the core's single-cycle data access into a two-phase sram-like bus transaction: address handshake (req/addr_ok), then data handshake (data_ok). It produces a stall back to the pipeline. It holds the load result until the pipeline is free to advance.

Parameters:
ADDR_W, 32, address width on core and bus sides
DATA_W, 32, data width on core and bus sides

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  one clock; reset is asynchronous and active-low (rst=0 resets)
cpu_en  in  1  core M-stage memory access valid (load or store)
cpu_wen  in  4  byte write enables (memwriteM); 0 = load
cpu_size  in  2  access size: 0 byte, 1 half, 2 word
cpu_addr  in  ADDR_W  physical address (MMU data_paddr)
cpu_wdata  in  DATA_W  store data (writedataM)
cpu_flush  in  1  M-stage flush (exception/eret); suppresses a not-yet-issued request
longest_stall  in  1  pipeline stalled by another source this cycle
cpu_rdata  out  DATA_W  load data to core (readdataM)
d_stall  out  1  stall request to hazard unit
data_req  out  1  sram-like request
data_wr  out  1  1 = write
data_size  out  2  sram-like size
data_addr  out  ADDR_W  sram-like address
data_wdata  out  DATA_W  sram-like write data
data_addr_ok  in  1  address phase accepted
data_data_ok  in  1  data phase complete
data_rdata  in  DATA_W  read data, valid with data_data_ok

Behaviour:
- States: IDLE, ADDR (request presented, not accepted), DATA (accepted, awaiting data_ok), DONE (complete, waiting for pipeline release). Reset -> IDLE.
- data_req = rst & cpu_en & ~cpu_flush & (state==IDLE | state==ADDR). It is never asserted in DATA or DONE: only one outstanding transaction.
- data_wr = |cpu_wen. data_size = cpu_size. data_addr = cpu_addr. data_wdata = cpu_wdata. These are combinational pass-throughs. The core holds them stable while d_stall=1.
- Transitions:
  - IDLE: req & addr_ok & data_ok -> DONE. req & addr_ok -> DATA. req & ~addr_ok -> ADDR. Otherwise stay.
  - ADDR: addr_ok & data_ok -> DONE. addr_ok -> DATA. Otherwise stay. cpu_flush in ADDR -> IDLE, request withdrawn.
  - DATA: data_ok -> DONE. Otherwise stay. cpu_flush is ignored: the accepted transaction must complete, and its result is discarded by the core.
  - DONE: ~longest_stall -> IDLE. Otherwise stay, with no reissue even though cpu_en is still high.
- rdata_q captures data_rdata on every cycle with data_data_ok & (state==ADDR|DATA|IDLE-with-accepted-req). cpu_rdata = rdata_q. rdata_q resets to 0. It holds until the next capture.
- d_stall = rst & cpu_en & ~cpu_flush & (state != DONE). The stall is released one cycle after data_ok (registered completion; no data_ok->stall combinational path). Minimum access latency is 2 cycles (req cycle + DONE).
- data_ok arriving in IDLE without an accepted request (e.g. after reset mid-transaction) is ignored: no state change, no capture.
- Async reset mid-transaction: state -> IDLE, rdata_q -> 0, data_req/d_stall forced 0 while rst=0.
- Alignment is not checked here. Address exceptions are raised upstream and appear as cpu_flush/cpu_en=0.

Decomposition:
- Shared package: state encoding (IDLE, ADDR, DATA, DONE as 2-bit constants); size constants SIZE_B=0, SIZE_H=1, SIZE_W=2.
- No sub-module. The FSM plus rdata register stay in one module. A twin instance (cpu_en tied by fetch, wen=0, size=2) serves the instruction side.

Test Plan:
- Word load 0x0000_1000, addr_ok in issue cycle, data_ok 3 cycles later with 0xDEAD_BEEF -> req high exactly 1 cycle, d_stall high 4 cycles, cpu_rdata=0xDEAD_BEEF on release.
- Store wen=4'b0011, size=1, addr_ok withheld 2 cycles -> data_wr=1, size=1, req high 3 cycles, then one data_ok -> DONE, stall drops next cycle.
- Load completes while longest_stall=1 for 3 cycles -> stays DONE, no second req, d_stall=0, cpu_rdata stable; leaves DONE when longest_stall=0.
- cpu_flush asserted in ADDR -> req drops same cycle, state IDLE. cpu_flush in DATA -> waits for data_ok, then DONE.
- rst pulled low in DATA, then stray data_ok after release -> state IDLE, cpu_rdata=0, no capture, no req.
- Back-to-back loads on consecutive instructions, addr_ok&data_ok same cycle -> each access takes 2 cycles, two distinct reqs, correct rdata per access.

Source files
------------

// File: rtl/data_sram_like_bridge_pkg.sv
// Shared definitions for the core-to-sram-like data bridge.
// Holds the bridge state encoding and the sram-like access size codes.
package data_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// sram-like bus bundle between the bridge (master) and the memory side (slave).
// master drives: data_req, data_wr, data_size, data_addr, data_wdata
// slave drives : data_addr_ok, data_data_ok, data_rdata
interface data_sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge.sv
// Converts the core's single-cycle M-stage data access into a two-phase
// sram-like transaction (address handshake, then data handshake), stalls the
// pipeline while the access is in flight and holds the load result until the
// pipeline is released.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   cpu_en_i          M-stage memory access valid
//   cpu_wen_i         byte write enables (0 = load)
//   cpu_size_i        access size (byte/half/word)
//   cpu_addr_i        physical address
//   cpu_wdata_i       store data
//   cpu_flush_i       M-stage flush; withdraws a not-yet-accepted request
//   longest_stall_i   pipeline held by another stall source
//   cpu_rdata_o       load data to the core (registered)
//   d_stall_o         stall request to the hazard unit
//   bus               sram-like master port
//
// State | meaning
// IDLE  | no transaction; a valid access is presented on the bus this cycle
// ADDR  | request presented, address phase not yet accepted
// DATA  | address accepted, awaiting data_data_ok
// DONE  | transaction complete, waiting for the pipeline to advance
module data_sram_like_bridge
    import data_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en_i,
    input  logic [3:0]          cpu_wen_i,
    input  logic [1:0]          cpu_size_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic                cpu_flush_i,
    input  logic                longest_stall_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                d_stall_o,
    data_sram_like_bridge_if.master bus
);

    bridge_state_e     state_q;
    logic [DATA_W-1:0] rdata_q;

    logic access_v;
    logic req;
    logic accepted;

    // Access is live only while out of reset and not flushed; gating with rst
    // keeps req/stall low during an asynchronous reset pulse.
    assign access_v = rst & cpu_en_i & ~cpu_flush_i;
    assign req      = access_v & ((state_q == ST_IDLE) | (state_q == ST_ADDR));
    assign accepted = req & bus.data_addr_ok;

    assign bus.data_req   = req;
    assign bus.data_wr    = |cpu_wen_i;
    assign bus.data_size  = cpu_size_i;
    assign bus.data_addr  = cpu_addr_i;
    assign bus.data_wdata = cpu_wdata_i;

    // Completion is seen through the registered DONE state, so there is no
    // combinational path from data_data_ok to the stall.
    assign d_stall_o   = access_v & (state_q != ST_DONE);
    assign cpu_rdata_o = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ADDR: begin
                    // A stray data_ok with no accepted request is ignored here.
                    if (accepted && bus.data_data_ok) begin
                        state_q <= ST_DONE;
                        rdata_q <= bus.data_rdata;
                    end else if (accepted) begin
                        state_q <= ST_DATA;
                    end else if (req) begin
                        state_q <= ST_ADDR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Flush is ignored: the accepted transaction must finish.
                    if (bus.data_data_ok) begin
                        state_q <= ST_DONE;
                        rdata_q <= bus.data_rdata;
                    end
                end
                ST_DONE: begin
                    if (!longest_stall_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
module tb_data_sram_like_bridge;
    import data_sram_like_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        longest_stall;
    logic [31:0] cpu_rdata;
    logic        d_stall;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_rdata;

    data_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_en_i        (cpu_en),
        .cpu_wen_i       (cpu_wen),
        .cpu_size_i      (cpu_size),
        .cpu_addr_i      (cpu_addr),
        .cpu_wdata_i     (cpu_wdata),
        .cpu_flush_i     (cpu_flush),
        .longest_stall_i (longest_stall),
        .cpu_rdata_o     (cpu_rdata),
        .d_stall_o       (d_stall),
        .bus             (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one access: with the address accepted aw cycles after
    // issue and data returned dw cycles after acceptance, the request is seen
    // for aw+1 cycles, the stall for aw+dw+1 cycles, and the returned word is
    // what the core reads once the stall drops. The pipeline may then hold the
    // bridge for ls further cycles with no reissue.
    task automatic access(input logic [3:0] wen, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int aw, input int dw,
                          input int ls);
        int nreq;
        int nstall;
        nreq   = 0;
        nstall = 0;
        cpu_en        = 1'b1;
        cpu_wen       = wen;
        cpu_size      = size;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_flush     = 1'b0;
        longest_stall = 1'b0;
        for (int k = 0; k <= aw + dw; k++) begin
            bus.data_addr_ok = (k == aw);
            bus.data_data_ok = (k == aw + dw);
            bus.data_rdata   = (k == aw + dw) ? rdata : $urandom;
            @(negedge clk);
            if (bus.data_req) nreq++;
            if (d_stall) nstall++;
            if (k == 0) begin
                chk("wr", {31'd0, bus.data_wr}, {31'd0, (wen != 4'd0)});
                chk("size", {30'd0, bus.data_size}, {30'd0, size});
                chk("addr", bus.data_addr, addr);
                chk("wdata", bus.data_wdata, wdata);
            end
            next_cycle();
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = $urandom;
        exp_rdata        = rdata;
        chk("req_cycles", nreq, aw + 1);
        chk("stall_cycles", nstall, aw + dw + 1);
        for (int j = 0; j <= ls; j++) begin
            longest_stall = (j < ls);
            @(negedge clk);
            chk("done_stall", {31'd0, d_stall}, 32'd0);
            chk("done_req", {31'd0, bus.data_req}, 32'd0);
            chk("done_rdata", cpu_rdata, exp_rdata);
            next_cycle();
        end
        longest_stall = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        cpu_en           = 1'b1;
        cpu_wen          = 4'd0;
        cpu_size         = SIZE_W;
        cpu_addr         = 32'h0;
        cpu_wdata        = 32'h0;
        cpu_flush        = 1'b0;
        longest_stall    = 1'b0;
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hFFFF_FFFF;
        exp_rdata        = 32'h0;

        // Reset state: outputs quiet even with an access and bus responses present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, bus.data_req}, 32'd0);
        chk("rst_stall", {31'd0, d_stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        cpu_en           = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        rst              = 1'b1;
        next_cycle();

        // Word load, address accepted at issue, data three cycles later.
        access(4'd0, SIZE_W, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 3, 0);
        // Half store with the address phase withheld two cycles.
        access(4'b0011, SIZE_H, 32'h0000_2002, 32'h0000_A5A5, 32'h1357_9BDF, 2, 1, 0);
        // Load completing under an external stall held for three cycles.
        access(4'd0, SIZE_W, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 1, 3);
        // Back-to-back loads, both handshakes in the issue cycle.
        access(4'd0, SIZE_W, 32'h0000_4000, 32'h0, 32'h1111_2222, 0, 0, 0);
        access(4'd0, SIZE_B, 32'h0000_4005, 32'h0, 32'h3333_4444, 0, 0, 0);
        cpu_en = 1'b0;
        next_cycle();

        // Flush while the request waits for address acceptance.
        cpu_en   = 1'b1;
        cpu_wen  = 4'd0;
        cpu_addr = 32'h0000_5000;
        @(negedge clk);
        chk("fa_req_before", {31'd0, bus.data_req}, 32'd1);
        next_cycle();
        cpu_flush = 1'b1;
        @(negedge clk);
        chk("fa_req_flush", {31'd0, bus.data_req}, 32'd0);
        chk("fa_stall_flush", {31'd0, d_stall}, 32'd0);
        next_cycle();
        cpu_flush = 1'b0;
        cpu_en    = 1'b0;
        next_cycle();
        access(4'd0, SIZE_W, 32'h0000_5100, 32'h0, 32'h5555_AAAA, 1, 0, 0);

        // Flush after acceptance: transaction still completes and captures.
        cpu_en           = 1'b1;
        cpu_addr         = 32'h0000_6000;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        chk("fd_req", {31'd0, bus.data_req}, 32'd1);
        next_cycle();
        bus.data_addr_ok = 1'b0;
        cpu_flush        = 1'b1;
        @(negedge clk);
        chk("fd_req_data", {31'd0, bus.data_req}, 32'd0);
        chk("fd_rdata_hold", cpu_rdata, exp_rdata);
        next_cycle();
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h6666_7777;
        next_cycle();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        cpu_flush        = 1'b0;
        cpu_en           = 1'b0;
        exp_rdata        = 32'h6666_7777;
        @(negedge clk);
        chk("fd_rdata", cpu_rdata, exp_rdata);
        next_cycle();
        access(4'd0, SIZE_W, 32'h0000_6100, 32'h0, 32'h7777_8888, 0, 2, 0);

        // Asynchronous reset in the data phase, then a stray data_ok.
        cpu_en           = 1'b1;
        cpu_addr         = 32'h0000_7000;
        bus.data_addr_ok = 1'b1;
        next_cycle();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_req", {31'd0, bus.data_req}, 32'd0);
        chk("ar_stall", {31'd0, d_stall}, 32'd0);
        chk("ar_rdata", cpu_rdata, 32'h0);
        next_cycle();
        rst              = 1'b1;
        cpu_en           = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1234_5678;
        next_cycle();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("ar_stray_rdata", cpu_rdata, 32'h0);
        chk("ar_stray_req", {31'd0, bus.data_req}, 32'd0);
        exp_rdata = 32'h0;
        next_cycle();
        access(4'd0, SIZE_W, 32'h0000_7100, 32'h0, 32'h9999_0000, 0, 0, 0);

        // Randomised back-to-back accesses.
        for (int i = 0; i < 24; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            access(w, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                cpu_en = 1'b0;
                next_cycle();
            end
        end
        cpu_en = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
